return_sequencer: RTL and testbench
===================================

RETURN_SEQUENCER -- requirements
Module: return_sequencer

Interface
REQ-001 Parameter kTotalBits, default from shared def file, width of all money quantities.
REQ-002 Parameter kWaitTime, default 100, idle cycles before automatic change return.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 i_coin_event  input  1  pulse: coin inserted this cycle.
REQ-006 i_item_event  input  1  pulse: item dispensed this cycle.
REQ-007 i_trigger_return  input  1  pulse: user requests change.
REQ-008 i_current_total  input  kTotalBits  credit currently held by the datapath.
REQ-009 o_return_valid  output  1  a return coin is being offered.
REQ-010 i_return_ready  input  1  coin hopper accepts the offered coin.
REQ-011 o_return_coin  output  3  one-hot coin index: bit0=100, bit1=500, bit2=1000.
REQ-012 o_return_total  output  kTotalBits  value of the coin accepted this cycle, else 0; drives the datapath subtract port.
REQ-013 o_wait_time  output  32  remaining wait cycles.
REQ-014 o_input_block  output  1  high while returning; datapath ignores coin/item requests.
REQ-015 o_residue  output  1  one-cycle pulse: return ended with a nonzero remainder below 100.

Function
REQ-016 FSM states SHALL be IDLE, ARMED, RETURN.
REQ-017 IDLE -> ARMED when i_current_total != 0, loading o_wait_time = kWaitTime.
REQ-018 In ARMED, any i_coin_event or i_item_event SHALL reload o_wait_time = kWaitTime; otherwise o_wait_time decrements by 1 per cycle, saturating at 0.
REQ-019 ARMED -> RETURN when i_trigger_return = 1, or when o_wait_time = 0; trigger takes priority over a simultaneous coin/item event.
REQ-020 ARMED -> IDLE when i_current_total = 0 and no trigger; o_wait_time cleared to 0.
REQ-021 On entry to RETURN, an internal remaining register SHALL latch i_current_total.
REQ-022 In RETURN, o_return_coin SHALL select the largest coin with value <= remaining; o_return_valid = 1 while remaining >= 100.
REQ-023 A coin is transferred only in a cycle where o_return_valid and i_return_ready are both 1; in that cycle, o_return_total = coin value and remaining decrements by that value the next cycle.
REQ-024 o_return_valid and o_return_coin SHALL remain stable while i_return_ready = 0.
REQ-025 Throughput: one coin per cycle while i_return_ready is held at 1.
REQ-026 RETURN -> IDLE when remaining = 0; when 0 < remaining < 100, also pulse o_residue for one cycle.
REQ-027 In RETURN, i_coin_event, i_item_event, i_trigger_return and changes on i_current_total SHALL be ignored; o_input_block = 1 only in RETURN.
REQ-028 Subtraction SHALL be unsigned, kTotalBits wide, and never underflow, which REQ-022 guarantees.

Reset
REQ-029 reset_n low SHALL asynchronously force IDLE, remaining = 0, o_wait_time = 0, o_return_valid = 0, o_return_coin = 0, o_return_total = 0, o_input_block = 0, o_residue = 0.
REQ-030 Reset asserted mid-RETURN SHALL abort the return immediately; no coin is counted as returned in that cycle.

Structure
REQ-031 kTotalBits, coin values (100/500/1000), coin count, and kWaitTime default SHALL live in the shared vending machine def include.
REQ-032 The FSM state encoding SHALL be a localparam set in the same def include.
REQ-033 One sub-module, coin_select (combinational largest-coin-<=-remaining picker), is natural; everything else stays flat.

Verification
REQ-034 Total=1600, trigger pulse, ready held 1 -> coins 1000, 500, 100 on consecutive cycles; o_return_total = 1000, 500, 100; then IDLE.
REQ-035 Total=500, no events, kWaitTime=100 -> RETURN entered exactly 100 cycles after ARMED; one 500 coin returned.
REQ-036 ARMED with o_wait_time=3, coin event -> o_wait_time = 100 next cycle; no return.
REQ-037 Total=1100, ready toggling 0/1 -> valid/coin stable during ready=0; exactly two transfers (1000, 100).
REQ-038 Total=150, trigger -> one 100 coin, then o_residue pulse, IDLE.
REQ-039 reset_n low during RETURN after the first coin -> all outputs 0 in the same cycle; IDLE after release.

Source files
------------

// File: rtl/return_sequencer_pkg.sv
// Shared vending machine definitions: credit width, coin set, wait time
// and the return sequencer state encoding.
package return_sequencer_pkg;

    localparam int kTotalBitsDef = 16;
    localparam int kWaitTimeDef = 100;
    localparam int kCoinCount = 3;

    localparam int kCoin100 = 100;
    localparam int kCoin500 = 500;
    localparam int kCoin1000 = 1000;

    localparam logic [1:0] kStIdle = 2'd0;
    localparam logic [1:0] kStArmed = 2'd1;
    localparam logic [1:0] kStReturn = 2'd2;

    typedef enum logic [1:0] {
        IDLE = kStIdle,
        ARMED = kStArmed,
        RETURN = kStReturn
    } state_t;

endpackage

// File: rtl/coin_select.sv
// Combinational picker: largest coin whose value fits in the remaining credit.
module coin_select
    import return_sequencer_pkg::*;
#(
    parameter int kTotalBits = kTotalBitsDef
) (
    input  logic [kTotalBits-1:0] remaining,
    output logic [kCoinCount-1:0] coin,
    output logic [kTotalBits-1:0] value,
    output logic                  has_coin
);

    always_comb begin
        coin = '0;
        value = '0;
        has_coin = 1'b1;
        if (remaining >= kTotalBits'(kCoin1000)) begin
            coin[2] = 1'b1;
            value = kTotalBits'(kCoin1000);
        end else if (remaining >= kTotalBits'(kCoin500)) begin
            coin[1] = 1'b1;
            value = kTotalBits'(kCoin500);
        end else if (remaining >= kTotalBits'(kCoin100)) begin
            coin[0] = 1'b1;
            value = kTotalBits'(kCoin100);
        end else begin
            has_coin = 1'b0;
        end
    end

endmodule

// File: rtl/return_sequencer.sv
// Change return sequencer: arms on credit, returns coins on trigger or
// idle timeout, one coin per accepted handshake, largest coin first.
module return_sequencer
    import return_sequencer_pkg::*;
#(
    parameter int kTotalBits = kTotalBitsDef,
    parameter int kWaitTime = kWaitTimeDef
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_coin_event,
    input  logic                  i_item_event,
    input  logic                  i_trigger_return,
    input  logic [kTotalBits-1:0] i_current_total,
    output logic                  o_return_valid,
    input  logic                  i_return_ready,
    output logic [2:0]            o_return_coin,
    output logic [kTotalBits-1:0] o_return_total,
    output logic [31:0]           o_wait_time,
    output logic                  o_input_block,
    output logic                  o_residue
);

    state_t state_q, state_d;
    logic [kTotalBits-1:0] remaining_q, remaining_d;
    logic [31:0] wait_q, wait_d;

    logic [kCoinCount-1:0] sel_coin;
    logic [kTotalBits-1:0] sel_value;
    logic has_coin;
    logic in_return;
    logic xfer;

    coin_select #(
        .kTotalBits(kTotalBits)
    ) u_coin_select (
        .remaining(remaining_q),
        .coin     (sel_coin),
        .value    (sel_value),
        .has_coin (has_coin)
    );

    // All outputs derive from registered state so reset clears them at once.
    assign in_return = (state_q == RETURN);
    assign o_return_valid = in_return && has_coin;
    assign o_return_coin = o_return_valid ? sel_coin : '0;
    assign xfer = o_return_valid && i_return_ready;
    assign o_return_total = xfer ? sel_value : '0;
    assign o_input_block = in_return;
    assign o_residue = in_return && !has_coin && (remaining_q != '0);
    assign o_wait_time = wait_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            remaining_q <= '0;
            wait_q <= '0;
        end else begin
            state_q <= state_d;
            remaining_q <= remaining_d;
            wait_q <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        remaining_d = remaining_q;
        wait_d = wait_q;
        unique case (state_q)
            IDLE: begin
                if (i_current_total != '0) begin
                    state_d = ARMED;
                    wait_d = 32'(kWaitTime);
                end
            end
            ARMED: begin
                // Last count (1 -> 0) enters RETURN on the same edge.
                if (i_trigger_return) begin
                    state_d = RETURN;
                    remaining_d = i_current_total;
                    wait_d = '0;
                end else if (i_current_total == '0) begin
                    state_d = IDLE;
                    wait_d = '0;
                end else if (wait_q == '0) begin
                    state_d = RETURN;
                    remaining_d = i_current_total;
                end else if (i_coin_event || i_item_event) begin
                    wait_d = 32'(kWaitTime);
                end else if (wait_q == 32'd1) begin
                    state_d = RETURN;
                    remaining_d = i_current_total;
                    wait_d = '0;
                end else begin
                    wait_d = wait_q - 32'd1;
                end
            end
            RETURN: begin
                if (xfer) begin
                    remaining_d = remaining_q - sel_value;
                end else if (!has_coin) begin
                    state_d = IDLE;
                    remaining_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_return_sequencer.sv
// Directed self-checking bench for return_sequencer.
module tb_return_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_coin_event;
    logic        i_item_event;
    logic        i_trigger_return;
    logic [15:0] i_current_total;
    logic        o_return_valid;
    logic        i_return_ready;
    logic [2:0]  o_return_coin;
    logic [15:0] o_return_total;
    logic [31:0] o_wait_time;
    logic        o_input_block;
    logic        o_residue;

    int n_cmp = 0;
    int n_bad = 0;
    int xfers = 0;
    int base;

    return_sequencer dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_coin_event    (i_coin_event),
        .i_item_event    (i_item_event),
        .i_trigger_return(i_trigger_return),
        .i_current_total (i_current_total),
        .o_return_valid  (o_return_valid),
        .i_return_ready  (i_return_ready),
        .o_return_coin   (o_return_coin),
        .o_return_total  (o_return_total),
        .o_wait_time     (o_wait_time),
        .o_input_block   (o_input_block),
        .o_residue       (o_residue)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (reset_n && o_return_valid && i_return_ready)
            xfers <= xfers + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        i_coin_event = 1'b0;
        i_item_event = 1'b0;
        i_trigger_return = 1'b0;
        i_current_total = '0;
        i_return_ready = 1'b0;
        repeat (2) tick();
        check("rst_valid", o_return_valid, 0);
        check("rst_coin", o_return_coin, 0);
        check("rst_total", o_return_total, 0);
        check("rst_wait", o_wait_time, 0);
        check("rst_block", o_input_block, 0);
        check("rst_residue", o_residue, 0);
        reset_n = 1'b1;
        tick();

        // 1600 on trigger: 1000, 500, 100 back to back
        i_current_total = 16'd1600;
        tick();
        check("t1_wait", o_wait_time, 100);
        check("t1_block", o_input_block, 0);
        i_trigger_return = 1'b1;
        i_return_ready = 1'b1;
        tick();
        i_trigger_return = 1'b0;
        i_current_total = '0;
        #1;
        check("t1_valid0", o_return_valid, 1);
        check("t1_coin0", o_return_coin, 3'b100);
        check("t1_tot0", o_return_total, 1000);
        tick();
        check("t1_coin1", o_return_coin, 3'b010);
        check("t1_tot1", o_return_total, 500);
        tick();
        check("t1_coin2", o_return_coin, 3'b001);
        check("t1_tot2", o_return_total, 100);
        tick();
        check("t1_valid_end", o_return_valid, 0);
        check("t1_tot_end", o_return_total, 0);
        check("t1_residue", o_residue, 0);
        tick();
        check("t1_idle", o_input_block, 0);
        check("t1_idle_wait", o_wait_time, 0);

        // 500 with no events: timeout after exactly 100 cycles
        i_current_total = 16'd500;
        tick();
        check("t2_wait", o_wait_time, 100);
        repeat (99) tick();
        check("t2_wait1", o_wait_time, 1);
        check("t2_armed", o_input_block, 0);
        tick();
        i_current_total = '0;
        #1;
        check("t2_block", o_input_block, 1);
        check("t2_coin", o_return_coin, 3'b010);
        check("t2_tot", o_return_total, 500);
        tick();
        check("t2_valid_end", o_return_valid, 0);
        tick();
        check("t2_idle", o_input_block, 0);

        // coin event at wait=3 reloads the timer
        i_return_ready = 1'b0;
        i_current_total = 16'd300;
        tick();
        repeat (97) tick();
        check("t3_wait3", o_wait_time, 3);
        i_coin_event = 1'b1;
        tick();
        i_coin_event = 1'b0;
        check("t3_reload", o_wait_time, 100);
        check("t3_no_ret", o_input_block, 0);
        tick();
        check("t3_dec", o_wait_time, 99);
        i_current_total = '0;
        tick();
        check("t3_idle_wait", o_wait_time, 0);
        check("t3_idle", o_input_block, 0);

        // 1100 with ready toggling: stable offer, two transfers
        i_current_total = 16'd1100;
        tick();
        i_trigger_return = 1'b1;
        tick();
        i_trigger_return = 1'b0;
        i_current_total = '0;
        base = xfers;
        #1;
        check("t4_coin_a", o_return_coin, 3'b100);
        check("t4_tot_stall", o_return_total, 0);
        tick();
        check("t4_valid_hold", o_return_valid, 1);
        check("t4_coin_hold", o_return_coin, 3'b100);
        i_return_ready = 1'b1;
        #1;
        check("t4_tot_a", o_return_total, 1000);
        tick();
        i_return_ready = 1'b0;
        #1;
        check("t4_coin_b", o_return_coin, 3'b001);
        check("t4_tot_stall2", o_return_total, 0);
        tick();
        check("t4_coin_b_hold", o_return_coin, 3'b001);
        i_return_ready = 1'b1;
        #1;
        check("t4_tot_b", o_return_total, 100);
        tick();
        check("t4_valid_end", o_return_valid, 0);
        check("t4_xfers", xfers - base, 2);
        i_return_ready = 1'b0;
        tick();
        check("t4_idle", o_input_block, 0);

        // 150: one 100 coin then residue pulse
        i_current_total = 16'd150;
        tick();
        i_trigger_return = 1'b1;
        i_return_ready = 1'b1;
        tick();
        i_trigger_return = 1'b0;
        i_current_total = '0;
        #1;
        check("t5_coin", o_return_coin, 3'b001);
        check("t5_tot", o_return_total, 100);
        check("t5_res0", o_residue, 0);
        tick();
        check("t5_valid", o_return_valid, 0);
        check("t5_res1", o_residue, 1);
        check("t5_block", o_input_block, 1);
        tick();
        check("t5_res_end", o_residue, 0);
        check("t5_idle", o_input_block, 0);

        // reset during RETURN after the first coin
        i_current_total = 16'd1600;
        tick();
        i_trigger_return = 1'b1;
        tick();
        i_trigger_return = 1'b0;
        i_current_total = '0;
        #1;
        check("t6_coin0", o_return_coin, 3'b100);
        tick();
        check("t6_coin1", o_return_coin, 3'b010);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_valid", o_return_valid, 0);
        check("t6_rst_coin", o_return_coin, 0);
        check("t6_rst_tot", o_return_total, 0);
        check("t6_rst_block", o_input_block, 0);
        check("t6_rst_residue", o_residue, 0);
        check("t6_rst_wait", o_wait_time, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("t6_idle", o_input_block, 0);
        check("t6_idle_valid", o_return_valid, 0);
        check("t6_idle_wait", o_wait_time, 0);
        i_return_ready = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
